// File: rtl/shared_pkg.sv
// Shared definitions for the SPI slave: FSM states, RAM opcodes
// and frame/read-data sizes.
package shared_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   localparam logic [1:0] RAM_WRITE_ADD  = 2'b00;
   localparam logic [1:0] RAM_WRITE_DATA = 2'b01;
   localparam logic [1:0] RAM_READ_ADD   = 2'b10;
   localparam logic [1:0] RAM_READ_DATA  = 2'b11;

   localparam int FRAME_LEN = 10;
   localparam int RD_WIDTH  = 8;

endpackage

// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM: collects 10-bit command
// frames on MOSI and shifts 8-bit read data back on MISO.
module spi_slave
   import shared_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [FRAME_LEN-1:0] rx_data,
   output logic                 rx_valid,
   input  logic [RD_WIDTH-1:0]  tx_data,
   input  logic                 tx_valid
);

   localparam logic [3:0] LAST_BIT   = 4'(FRAME_LEN - 1);
   localparam logic [3:0] FRAME_DONE = 4'(FRAME_LEN);
   localparam logic [3:0] TX_LAST    = 4'(RD_WIDTH);

   state_t               state;
   state_t               state_nxt;
   logic [FRAME_LEN-2:0] shreg;
   logic [3:0]           bit_cnt;
   logic [3:0]           tx_cnt;
   logic [RD_WIDTH-1:0]  tx_shift;
   logic                 tx_busy;
   logic                 tx_done;
   logic                 rd_addr_flag;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (SS_n) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nxt = CHK_CMD;
            CHK_CMD: begin
               if (!MOSI)
                  state_nxt = WRITE;
               else if (rd_addr_flag)
                  state_nxt = READ_DATA;
               else
                  state_nxt = READ_ADD;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg        <= '0;
         bit_cnt      <= '0;
         tx_cnt       <= '0;
         tx_shift     <= '0;
         tx_busy      <= 1'b0;
         tx_done      <= 1'b0;
         rd_addr_flag <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         MISO         <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (SS_n) begin
            // abort: drop partial frame and any read shift, keep the flag
            bit_cnt <= '0;
            tx_cnt  <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            MISO    <= 1'b0;
         end else begin
            unique case (state)
               IDLE: bit_cnt <= '0;
               CHK_CMD: begin
                  shreg   <= {shreg[FRAME_LEN-3:0], MOSI};
                  bit_cnt <= 4'd1;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (bit_cnt != FRAME_DONE) begin
                     shreg   <= {shreg[FRAME_LEN-3:0], MOSI};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == LAST_BIT) begin
                        rx_data  <= {shreg, MOSI};
                        rx_valid <= 1'b1;
                        if (state == READ_ADD)
                           rd_addr_flag <= 1'b1;
                     end
                  end else if (state == READ_DATA) begin
                     if (tx_busy) begin
                        if (tx_cnt == TX_LAST) begin
                           MISO         <= 1'b0;
                           tx_busy      <= 1'b0;
                           tx_done      <= 1'b1;
                           rd_addr_flag <= 1'b0;
                        end else begin
                           MISO     <= tx_shift[RD_WIDTH-1];
                           tx_shift <= {tx_shift[RD_WIDTH-2:0], 1'b0};
                           tx_cnt   <= tx_cnt + 4'd1;
                        end
                     end else if (!tx_done && tx_valid) begin
                        MISO     <= tx_data[RD_WIDTH-1];
                        tx_shift <= {tx_data[RD_WIDTH-2:0], 1'b0};
                        tx_cnt   <= 4'd1;
                        tx_busy  <= 1'b1;
                     end
                  end
               end
               default: bit_cnt <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus random
// frames against a transaction-level model of the slave.
module tb_spi_slave;
   import shared_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       SS_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;

   int total = 0;
   int bad = 0;

   logic       m_flag = 1'b0;
   logic [9:0] exp_rx = '0;
   logic       exp_rxv = 1'b0;
   logic       miso_q[$];

   spi_slave dut (
      .clk(clk),
      .rst(rst),
      .SS_n(SS_n),
      .MOSI(MOSI),
      .MISO(MISO),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .tx_data(tx_data),
      .tx_valid(tx_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // one clock; outputs are checked every cycle against the model
   task automatic tick();
      logic em;
      @(posedge clk);
      #1;
      em = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
      chk("miso", 16'(MISO), 16'(em));
      chk("rx_valid", 16'(rx_valid), 16'(exp_rxv));
      chk("rx_data", 16'(rx_data), 16'(exp_rx));
      exp_rxv = 1'b0;
   endtask

   task automatic frame(input logic [9:0] w, input int nbits,
                        input int hold, input bit do_tx,
                        input logic [7:0] txd, input int txwait,
                        input bit noise);
      state_t p;
      bit     waiting;
      if (!w[9])
         p = WRITE;
      else if (m_flag)
         p = READ_DATA;
      else
         p = READ_ADD;
      SS_n = 1'b0;
      tx_valid = noise;
      tx_data = 8'($urandom);
      tick();
      for (int i = 0; i < nbits; i++) begin
         MOSI = w[9-i];
         if (i == 9) begin
            exp_rxv = 1'b1;
            exp_rx = w;
         end
         tick();
         if (i == 0)
            chk("path", 16'(dut.state), 16'(p));
      end
      if (nbits == 10) begin
         if (p == READ_ADD)
            m_flag = 1'b1;
         chk("flag_frame", 16'(dut.rd_addr_flag), 16'(m_flag));
         tx_valid = 1'b0;
         waiting = (p == READ_DATA);
         if (waiting && do_tx) begin
            repeat (txwait) tick();
            tx_valid = 1'b1;
            tx_data = txd;
            for (int k = 7; k >= 0; k--)
               miso_q.push_back(txd[k]);
            tick();
            tx_valid = 1'b0;
            tx_data = 8'($urandom);
            repeat (7) tick();
            chk("flag_b8", 16'(dut.rd_addr_flag), 16'(m_flag));
            tick();
            m_flag = 1'b0;
            chk("flag_clr", 16'(dut.rd_addr_flag), 16'(m_flag));
            waiting = 1'b0;
         end
         tx_valid = noise && !waiting;
         repeat (hold) tick();
      end else begin
         MOSI = w[9-nbits];
      end
      SS_n = 1'b1;
      tx_valid = 1'b0;
      tick();
      chk("idle", 16'(dut.state), 16'(IDLE));
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      chk("rst_flag", 16'(dut.rd_addr_flag), 16'd0);
      chk("rst_state", 16'(dut.state), 16'(IDLE));
      rst = 1'b0;
      tick();

      // write address, then a read address / read data pair
      frame(10'h05A, 10, 2, 1'b0, 8'h00, 0, 1'b0);
      frame(10'h23C, 10, 1, 1'b0, 8'h00, 0, 1'b0);
      frame(10'h300, 10, 1, 1'b1, 8'hA5, 0, 1'b0);

      // aborts: mid-write, and SS_n rising with bit 10 of a read address
      frame(10'h0F3, 5, 0, 1'b0, 8'h00, 0, 1'b0);
      frame(10'h2C7, 9, 0, 1'b0, 8'h00, 0, 1'b0);
      chk("abort_flag", 16'(dut.rd_addr_flag), 16'(m_flag));

      // reset in the middle of the MISO shift
      frame(10'h211, 10, 0, 1'b0, 8'h00, 0, 1'b0);
      SS_n = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         MOSI = i[0];
         if (i == 9) begin
            exp_rxv = 1'b1;
            exp_rx = 10'h355;
         end
         if (i == 0)
            MOSI = 1'b1;
         tick();
      end
      tx_valid = 1'b1;
      tx_data = 8'h96;
      for (int k = 7; k >= 0; k--)
         miso_q.push_back(tx_data[k]);
      tick();
      tx_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      miso_q.delete();
      exp_rx = '0;
      m_flag = 1'b0;
      tick();
      chk("rst_mid_flag", 16'(dut.rd_addr_flag), 16'd0);
      chk("rst_mid_state", 16'(dut.state), 16'(IDLE));
      rst = 1'b0;
      SS_n = 1'b1;
      tick();
      frame(10'h2AA, 10, 0, 1'b0, 8'h00, 0, 1'b0);
      frame(10'h3FF, 10, 0, 1'b1, 8'h3C, 2, 1'b1);

      // spurious tx_valid during a write, then back-to-back writes
      frame(10'h1E1, 10, 2, 1'b0, 8'h00, 0, 1'b1);
      frame(10'h012, 10, 0, 1'b0, 8'h00, 0, 1'b0);
      frame(10'h1ED, 10, 0, 1'b0, 8'h00, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [9:0] w;
         int         nb;
         w = 10'($urandom);
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 10;
         frame(w, nb, $urandom_range(0, 2), 1'($urandom),
               8'($urandom), $urandom_range(0, 3), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
